// File: rtl/bit32_pip_skid.sv
// bit32_pip_skid: elastic two-entry pipeline register (main + skid) for a
// MIPS32 inter-stage boundary. It stands in for a plain enable register where
// the downstream stage can stall.
//
// Ports:
//   che        clock, rising edge
//   rst        asynchronous reset, active low
//   flush      synchronous squash; invalidates every held entry
//   in_valid   upstream offers in_data
//   in_ready   block can accept (registered, no path from out_ready)
//   in_data    upstream payload, W bits
//   out_valid  out_data holds a valid entry
//   out_ready  downstream takes out_data this cycle
//   out_data   oldest held entry, driven straight from the main register
//   stall_cnt  16-bit saturating stall counter (only with PIP_STALL_CNT_EN)
//
// Optional feature: define PIP_STALL_CNT_EN to add the stall_cnt output.

module bit32_pip_skid #(
  parameter int unsigned W = 32
) (
  input  logic         che,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
`ifdef PIP_STALL_CNT_EN
  output logic [W-1:0] out_data,
  output logic [15:0]  stall_cnt
`else
  output logic [W-1:0] out_data
`endif
);

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         in_ready_q, in_ready_d;
  logic         accept;
  logic         fire;

  // Accept is qualified by the registered ready, so FULL can never accept.
  assign accept = in_valid && in_ready_q;
  assign fire   = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      // Entries are invalidated, not cleared; offered data is dropped.
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            state_d = StOne;
            main_d  = in_data;
          end
        end
        StOne: begin
          if (accept && fire) begin
            main_d = in_data;
          end else if (accept) begin
            state_d = StFull;
            skid_d  = in_data;
          end else if (fire) begin
            state_d = StEmpty;
          end
        end
        StFull: begin
          if (fire) begin
            state_d = StOne;
            main_d  = skid_q;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
    in_ready_d = (state_d != StFull);
  end

  always_ff @(posedge che or negedge rst) begin
    if (!rst) begin
      state_q    <= StEmpty;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign out_valid = (state_q != StEmpty);
  assign out_data  = main_q;
  assign in_ready  = in_ready_q;

`ifdef PIP_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge che or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else if (flush) begin
      stall_cnt_q <= '0;
    end else if (out_valid && !out_ready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_bit32_pip_skid.sv
// Self-checking bench for bit32_pip_skid. The driver pushes every value it
// expects to see leave the block into a scoreboard queue; an independent
// monitor pops and compares on every output transfer.

module tb_bit32_pip_skid;

  logic        che = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
`ifdef PIP_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int errors = 0;
  int checks = 0;
  logic [31:0] sb[$];

  always #5 che = ~che;

  bit32_pip_skid #(.W(32)) dut (
    .che       (che),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef PIP_STALL_CNT_EN
    .out_data  (out_data),
    .stall_cnt (stall_cnt)
`else
    .out_data  (out_data)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge che);
    #1;
  endtask

  // Monitor: compare every output transfer against the scoreboard, and check
  // that a stalled entry does not change before it is taken.
  logic        prev_hold = 1'b0;
  logic [31:0] prev_data = '0;
  always @(negedge che) begin
    if (rst && out_valid && prev_hold) begin
      check("hold_stable", out_data, prev_data);
    end
    if (rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got %h expected no output at %0t", out_data, $time);
      end else begin
        check("sb_data", out_data, sb.pop_front());
      end
    end
    prev_hold = rst && out_valid && !out_ready && !flush;
    prev_data = out_data;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst       = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // Reset hold then release.
    #2;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    tick();
    tick();
    check("rst_hold_in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b1;
    #1;
    check("rel_in_ready_pre", {31'd0, in_ready}, 32'd0);
    tick();
    check("rel_in_ready", {31'd0, in_ready}, 32'd1);
    check("rel_out_valid", {31'd0, out_valid}, 32'd0);

    // Streaming at full rate: each value visible one edge after accept.
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = 32'(i);
      sb.push_back(32'(i));
      tick();
      check("stream_out_valid", {31'd0, out_valid}, 32'd1);
      check("stream_out_data", out_data, 32'(i));
      check("stream_in_ready", {31'd0, in_ready}, 32'd1);
    end
    in_valid = 1'b0;
    tick();
    check("stream_drained", {31'd0, out_valid}, 32'd0);

    // Fill main + skid with the consumer stalled, then release.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hAAAA0000;
    sb.push_back(32'hAAAA0000);
    tick();
    check("skid_one_ready", {31'd0, in_ready}, 32'd1);
    in_data = 32'hBBBB1111;
    sb.push_back(32'hBBBB1111);
    tick();
    in_valid = 1'b0;
    check("full_in_ready", {31'd0, in_ready}, 32'd0);
    check("full_out_data", out_data, 32'hAAAA0000);
    tick();
    check("full_held_data", out_data, 32'hAAAA0000);
    check("full_held_ready", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    tick();
    check("release_in_ready", {31'd0, in_ready}, 32'd1);
    check("release_out_data", out_data, 32'hBBBB1111);
    tick();
    check("release_empty", {31'd0, out_valid}, 32'd0);

    // Flush while FULL with a word offered in the same cycle.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h11112222;
    sb.push_back(32'h11112222);
    tick();
    in_data = 32'h33334444;
    sb.push_back(32'h33334444);
    tick();
    check("flush_pre_full", {31'd0, in_ready}, 32'd0);
    flush   = 1'b1;
    in_data = 32'hDEADBEEF;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    check("flush_out_valid", {31'd0, out_valid}, 32'd0);
    check("flush_in_ready", {31'd0, in_ready}, 32'd1);
    check("flush_keeps_main", out_data, 32'h11112222);
    out_ready = 1'b1;
    tick();
    tick();
    check("flush_no_ghost", {31'd0, out_valid}, 32'd0);

    // Asynchronous reset between edges.
    in_valid = 1'b1;
    in_data  = 32'h00000055;
    sb.push_back(32'h00000055);
    tick();
    in_valid = 1'b0;
    check("pre_arst_valid", {31'd0, out_valid}, 32'd1);
    #1;
    rst = 1'b0;
    #1;
    sb.delete();
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_out_data", out_data, 32'd0);
    check("arst_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    rst = 1'b1;
    tick();
    check("arst_rel_ready", {31'd0, in_ready}, 32'd1);

`ifdef PIP_STALL_CNT_EN
    // Stall counter: five stalled edges, flush clears, then saturation.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h00000077;
    sb.push_back(32'h00000077);
    tick();
    in_valid = 1'b0;
    check("cnt_start", {16'd0, stall_cnt}, 32'd0);
    repeat (5) tick();
    check("cnt_five", {16'd0, stall_cnt}, 32'd5);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    sb.delete();
    check("cnt_flush", {16'd0, stall_cnt}, 32'd0);
    in_valid = 1'b1;
    in_data  = 32'h00000099;
    sb.push_back(32'h00000099);
    tick();
    in_valid = 1'b0;
    repeat (65534) tick();
    check("cnt_fffe", {16'd0, stall_cnt}, 32'h0000FFFE);
    repeat (3) tick();
    check("cnt_sat", {16'd0, stall_cnt}, 32'h0000FFFF);
    out_ready = 1'b1;
    tick();
`endif

    // Drain whatever is left and confirm the scoreboard is empty.
    out_ready = 1'b1;
    for (int k = 0; k < 10 && sb.size() != 0; k++) tick();
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bit32_pip_skid.md
Name: bit32_pip_skid

Overview:
- Elastic two-entry pipeline register (main + skid) for MIPS32 inter-stage boundaries.
- Replaces a plain enable-register where the downstream stage can stall.
- Upstream side is a valid/ready producer interface; downstream side is a valid/ready consumer interface.
- Full throughput when not stalled; synchronous flush for branch/exception squash.

Parameters:
- W, 32, data width in bits.

Ports:
- che  input  1  clock; rising edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset).
- flush  input  1  synchronous squash of all held entries.
- in_valid  input  1  upstream presents in_data.
- in_ready  output  1  block can accept; registered.
- in_data  input  W  upstream payload.
- out_valid  output  1  out_data holds a valid entry.
- out_ready  input  1  downstream accepts this cycle.
- out_data  output  W  oldest held entry.

Behaviour:
- Transfers:
  - Accept = in_valid && in_ready at a che edge.
  - Fire = out_valid && out_ready at a che edge.
- State (2-bit): EMPTY, ONE (main valid), FULL (main + skid valid).
- Output decode:
  - out_valid = (state != EMPTY).
  - out_data = main register, driven directly from the register with no combinational path from inputs.
- in_ready:
  - Registered copy of next_state != FULL.
  - No combinational in_ready-from-out_ready path.
- Transitions (flush == 0):
  - EMPTY:
    - accept -> ONE, main <= in_data.
    - else stay.
  - ONE:
    - accept && fire -> ONE, main <= in_data.
    - accept only -> FULL, skid <= in_data.
    - fire only -> EMPTY.
    - neither -> hold.
  - FULL (in_ready = 0, so no accept):
    - fire -> ONE, main <= skid.
    - else hold; main and skid stable.
- Ordering: strictly FIFO; entries leave in acceptance order; no duplication, no loss unless flushed.
- flush == 1 (highest priority over accept/fire):
  - Next state EMPTY; in_ready <= 1.
  - Any in_data offered in the flush cycle is discarded, even if in_ready was 1.
  - A fire in the flush cycle still counts as consumed downstream.
  - main/skid contents are not cleared, only invalidated.
- Reset (rst == 0, asynchronous):
  - state = EMPTY, main = 0, skid = 0, out_valid = 0, out_data = 0.
  - in_ready = 0 while reset is asserted.
  - in_ready = 1 at the first che edge after rst deasserts.
- Reset mid-operation: held entries are lost; no partial transfer is completed.
- Data stability: while out_valid && !out_ready, out_data must not change.
- Steady-state streaming (out_ready = 1 always): latency in_data -> out_data is 1 cycle; throughput 1 per cycle.
- After a FULL stall releases: in_ready returns to 1 one cycle after the draining fire.

Optional Feature:
- Macro: PIP_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt [15:0].
  - Increments on each che edge with out_valid && !out_ready.
  - Saturates at 16'hFFFF.
  - Cleared by reset and by flush.
  - Holds otherwise.
- Undefined: stall_cnt port and its logic are absent; all other behaviour identical.

Test Plan:
- Reset hold then release, in_valid = 0 -> out_valid = 0, out_data = 0; in_ready = 0 during reset, 1 one edge after release.
- Stream 0x00000001..0x00000008 on consecutive cycles with out_ready = 1 -> same 8 values out in order, each 1 cycle after accept; in_ready stays 1.
- Accept 0xAAAA0000 and 0xBBBB1111 with out_ready = 0 -> state FULL, in_ready = 0, out_data = 0xAAAA0000 held. Then raise out_ready -> out 0xAAAA0000 then 0xBBBB1111; in_ready returns to 1.
- Flush while FULL, with in_valid = 1 and in_data = 0xDEADBEEF offered the same cycle -> next cycle out_valid = 0, in_ready = 1; 0xDEADBEEF never appears at out_data.
- Assert rst low asynchronously mid-stream between che edges -> out_valid and out_data go to 0 immediately, without waiting for a che edge.
- PIP_STALL_CNT_EN defined:
  - Hold 1 entry with out_ready = 0 for 5 cycles -> stall_cnt = 5.
  - Then flush -> stall_cnt = 0.
  - Preload 16'hFFFE and stall 3 cycles -> stall_cnt = 16'hFFFF.
